// File: rtl/reset_req_gen_pkg.sv
// Shared types, codes and parameter defaults for the reset request generator.
package reset_req_gen_pkg;

   localparam int unsigned CNT_W = 16;

   localparam int unsigned DEF_TICK_DIV    = 50000;
   localparam int unsigned DEF_DEB_MS      = 20;
   localparam int unsigned DEF_HRESET_MS   = 2000;
   localparam int unsigned DEF_FULL_MS     = 5000;
   localparam int unsigned DEF_POR_HOLD_MS = 100;
   localparam int unsigned DEF_REQ_PULSE   = 16;
   localparam int unsigned DEF_LOCK_MS     = 10;

   typedef enum logic [1:0] {
      REQ_SOFT = 2'd0,
      REQ_HARD = 2'd1,
      REQ_FULL = 2'd2,
      REQ_POR  = 2'd3
   } req_type_e;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_PWR  = 2'd1,
      SRC_BTN  = 2'd2,
      SRC_CMD  = 2'd3
   } src_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_POR_HOLD = 2'd1,
      ST_PULSE    = 2'd2,
      ST_LOCKOUT  = 2'd3
   } state_e;

   // Active-low request lines towards the DSP reset sequencer.
   typedef struct packed {
      logic por_n;
      logic full_n;
      logic hard_n;
      logic soft_n;
   } req_lines_t;

   // Saturating increment for all ms/cycle counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/reset_req_gen_if.sv
// Host command handshake and request outputs of the reset request generator.
interface reset_req_gen_if;
   logic       cmd_valid;
   logic [1:0] cmd_type;
   logic       cmd_ready;
   logic       por_req_n;
   logic       resetfull_req_n;
   logic       hreset_req_n;
   logic       sreset_req_n;
   logic [1:0] last_src;

   modport master (
      output cmd_valid, cmd_type,
      input  cmd_ready, por_req_n, resetfull_req_n, hreset_req_n, sreset_req_n, last_src
   );

   modport slave (
      input  cmd_valid, cmd_type,
      output cmd_ready, por_req_n, resetfull_req_n, hreset_req_n, sreset_req_n, last_src
   );
endinterface

// File: rtl/btn_press_classify.sv
// Front-panel button: synchroniser, debounce, press timer and duration classifier.
// rel_pulse is a one-cycle strobe on the debounced release; rel_type holds the class.
module btn_press_classify
   import reset_req_gen_pkg::*;
#(
   parameter int unsigned DEB_MS    = DEF_DEB_MS,
   parameter int unsigned HRESET_MS = DEF_HRESET_MS,
   parameter int unsigned FULL_MS   = DEF_FULL_MS
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      tick,
   input  logic      btn_n,
   output logic      rel_pulse,
   output req_type_e rel_type
);

   logic [1:0]       sync_q;
   logic             deb_n_q, deb_n_d;
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
   logic             rel_pulse_q, rel_pulse_d;
   req_type_e        rel_type_q, rel_type_d;

   function automatic req_type_e classify(input logic [CNT_W-1:0] d);
      if (d >= CNT_W'(FULL_MS))        return REQ_FULL;
      else if (d >= CNT_W'(HRESET_MS)) return REQ_HARD;
      else                             return REQ_SOFT;
   endfunction

   // Two-flop synchroniser, idles at released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], btn_n};
   end

   // Debounce on ms ticks, time the press, classify on release.
   always_comb begin
      deb_n_d     = deb_n_q;
      deb_cnt_d   = deb_cnt_q;
      press_cnt_d = press_cnt_q;
      rel_pulse_d = 1'b0;
      rel_type_d  = rel_type_q;

      if (!deb_n_q && tick) press_cnt_d = sat_inc(press_cnt_q);

      if (sync_q[1] == deb_n_q) begin
         deb_cnt_d = '0;
      end else if (tick) begin
         if (sat_inc(deb_cnt_q) >= CNT_W'(DEB_MS)) begin
            deb_n_d   = sync_q[1];
            deb_cnt_d = '0;
            if (!sync_q[1]) begin
               press_cnt_d = '0;
            end else begin
               rel_pulse_d = 1'b1;
               rel_type_d  = classify(press_cnt_q);
            end
         end else begin
            deb_cnt_d = sat_inc(deb_cnt_q);
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_n_q     <= 1'b1;
         deb_cnt_q   <= '0;
         press_cnt_q <= '0;
         rel_pulse_q <= 1'b0;
         rel_type_q  <= REQ_SOFT;
      end else begin
         deb_n_q     <= deb_n_d;
         deb_cnt_q   <= deb_cnt_d;
         press_cnt_q <= press_cnt_d;
         rel_pulse_q <= rel_pulse_d;
         rel_type_q  <= rel_type_d;
      end
   end

   assign rel_pulse = rel_pulse_q;
   assign rel_type  = rel_type_q;

endmodule

// File: rtl/reset_req_gen.sv
// Reset request generator: arbitrates power-good, button and host command into
// one fixed-width active-low request at a time, then locks out until the DSP
// has been out of reset for LOCK_MS.
// Build option: RESET_REQ_CMD_EN enables the host command port; when undefined
// commands are ignored and cmd_ready stays low.
module reset_req_gen
   import reset_req_gen_pkg::*;
#(
   parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
   parameter int unsigned DEB_MS      = DEF_DEB_MS,
   parameter int unsigned HRESET_MS   = DEF_HRESET_MS,
   parameter int unsigned FULL_MS     = DEF_FULL_MS,
   parameter int unsigned POR_HOLD_MS = DEF_POR_HOLD_MS,
   parameter int unsigned REQ_PULSE   = DEF_REQ_PULSE,
   parameter int unsigned LOCK_MS     = DEF_LOCK_MS
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           pwr_good,
   input  logic           btn_n,
   input  logic           cs_resetstat_n,
   reset_req_gen_if.slave bus
);

   logic [1:0]       pwr_sync_q;
   logic [1:0]       cs_sync_q;
   logic [CNT_W-1:0] div_q, div_d;
   logic             tick_c;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
   logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
   req_type_e        req_typ_q, req_typ_d;
   src_e             last_src_q, last_src_d;
   req_lines_t       req_q, req_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             rel_pulse;
   req_type_e        rel_type;
   logic             cmd_fire_c;
   req_type_e        cmd_type_c;

`ifdef RESET_REQ_CMD_EN
   localparam logic CMD_EN = 1'b1;
   assign cmd_fire_c = bus.cmd_valid & cmd_ready_q;
   assign cmd_type_c = req_type_e'(bus.cmd_type);
`else
   localparam logic CMD_EN = 1'b0;
   logic unused_cmd_c;
   assign unused_cmd_c = ^{bus.cmd_valid, bus.cmd_type};
   assign cmd_fire_c   = 1'b0;
   assign cmd_type_c   = REQ_SOFT;
`endif

   // Power path synchroniser resets to "good" so a low pwr_good is seen after two clks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwr_sync_q <= 2'b11;
         cs_sync_q  <= 2'b00;
      end else begin
         pwr_sync_q <= {pwr_sync_q[0], pwr_good};
         cs_sync_q  <= {cs_sync_q[0], cs_resetstat_n};
      end
   end

   // 1 ms tick divider.
   assign tick_c = (div_q == CNT_W'(TICK_DIV - 1));
   always_comb begin
      div_d = tick_c ? '0 : div_q + CNT_W'(1);
   end

   btn_press_classify #(
      .DEB_MS    (DEB_MS),
      .HRESET_MS (HRESET_MS),
      .FULL_MS   (FULL_MS)
   ) u_btn (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick_c),
      .btn_n     (btn_n),
      .rel_pulse (rel_pulse),
      .rel_type  (rel_type)
   );

   // Next state, counters and registered outputs derived from the next state.
   always_comb begin
      state_d     = state_q;
      ms_cnt_d    = ms_cnt_q;
      pulse_cnt_d = pulse_cnt_q;
      req_typ_d   = req_typ_q;
      last_src_d  = last_src_q;
      req_d       = '1;
      cmd_ready_d = 1'b0;

      if (!pwr_sync_q[1]) begin
         // Power loss preempts everything, including an active pulse.
         if (state_q != ST_POR_HOLD) last_src_d = SRC_PWR;
         state_d  = ST_POR_HOLD;
         ms_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rel_pulse) begin
                  state_d     = ST_PULSE;
                  req_typ_d   = rel_type;
                  last_src_d  = SRC_BTN;
                  pulse_cnt_d = '0;
               end else if (cmd_fire_c) begin
                  last_src_d = SRC_CMD;
                  if (cmd_type_c == REQ_POR) begin
                     state_d  = ST_POR_HOLD;
                     ms_cnt_d = '0;
                  end else begin
                     state_d     = ST_PULSE;
                     req_typ_d   = cmd_type_c;
                     pulse_cnt_d = '0;
                  end
               end
            end
            ST_POR_HOLD: begin
               if (ms_cnt_q >= CNT_W'(POR_HOLD_MS)) begin
                  state_d  = ST_LOCKOUT;
                  ms_cnt_d = '0;
               end else if (tick_c) begin
                  ms_cnt_d = sat_inc(ms_cnt_q);
               end
            end
            ST_PULSE: begin
               if (pulse_cnt_q >= CNT_W'(REQ_PULSE - 1)) begin
                  state_d  = ST_LOCKOUT;
                  ms_cnt_d = '0;
               end else begin
                  pulse_cnt_d = sat_inc(pulse_cnt_q);
               end
            end
            ST_LOCKOUT: begin
               if (!cs_sync_q[1]) begin
                  ms_cnt_d = '0;
               end else if (ms_cnt_q >= CNT_W'(LOCK_MS)) begin
                  state_d = ST_IDLE;
               end else if (tick_c) begin
                  ms_cnt_d = sat_inc(ms_cnt_q);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      case (state_d)
         ST_POR_HOLD: req_d.por_n = 1'b0;
         ST_PULSE: begin
            case (req_typ_d)
               REQ_SOFT: req_d.soft_n = 1'b0;
               REQ_HARD: req_d.hard_n = 1'b0;
               REQ_FULL: req_d.full_n = 1'b0;
               default:  req_d.por_n  = 1'b0;
            endcase
         end
         default: req_d = '1;
      endcase

      cmd_ready_d = CMD_EN && (state_d == ST_IDLE);
   end

   // State, counters and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q       <= '0;
         state_q     <= ST_IDLE;
         ms_cnt_q    <= '0;
         pulse_cnt_q <= '0;
         req_typ_q   <= REQ_SOFT;
         last_src_q  <= SRC_NONE;
         req_q       <= '1;
         cmd_ready_q <= 1'b0;
      end else begin
         div_q       <= div_d;
         state_q     <= state_d;
         ms_cnt_q    <= ms_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         req_typ_q   <= req_typ_d;
         last_src_q  <= last_src_d;
         req_q       <= req_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   assign bus.cmd_ready       = cmd_ready_q;
   assign bus.por_req_n       = req_q.por_n;
   assign bus.resetfull_req_n = req_q.full_n;
   assign bus.hreset_req_n    = req_q.hard_n;
   assign bus.sreset_req_n    = req_q.soft_n;
   assign bus.last_src        = last_src_q;

endmodule

// File: tb/tb_reset_req_gen.sv
// Directed bench for reset_req_gen with scaled-down timing parameters.
module tb_reset_req_gen;

`ifdef RESET_REQ_CMD_EN
   localparam logic CMD_EN = 1'b1;
`else
   localparam logic CMD_EN = 1'b0;
`endif

   localparam logic [3:0] P_IDLE = 4'b1111;
   localparam logic [3:0] P_SOFT = 4'b1110;
   localparam logic [3:0] P_HARD = 4'b1101;
   localparam logic [3:0] P_FULL = 4'b1011;
   localparam logic [3:0] P_POR  = 4'b0111;

   logic clk = 1'b0;
   logic rst_n;
   logic pwr_good;
   logic btn_n;
   logic cs_resetstat_n;
   int   errors = 0;
   int   checks = 0;
   int   cyc;
   int   cs_hold = 0;
   int   onehot_bad = 0;
   logic [3:0] reqs_n;

   reset_req_gen_if bus ();

   reset_req_gen #(
      .TICK_DIV    (10),
      .DEB_MS      (2),
      .HRESET_MS   (20),
      .FULL_MS     (50),
      .POR_HOLD_MS (5),
      .REQ_PULSE   (4),
      .LOCK_MS     (3)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pwr_good       (pwr_good),
      .btn_n          (btn_n),
      .cs_resetstat_n (cs_resetstat_n),
      .bus            (bus.slave)
   );

   always #5 clk = ~clk;

   assign reqs_n = {bus.por_req_n, bus.resetfull_req_n, bus.hreset_req_n, bus.sreset_req_n};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // DSP model: RESETSTATz low while any request is low and for 30 clks after.
   always @(negedge clk) begin
      if (reqs_n !== P_IDLE) cs_hold = 30;
      else if (cs_hold > 0)  cs_hold = cs_hold - 1;
      cs_resetstat_n = (cs_hold == 0);
      if (rst_n && !$onehot0(~reqs_n)) onehot_bad = onehot_bad + 1;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin errors++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end
   endtask

   task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi)
         else begin errors++; $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi); end
   endtask

   task automatic press(input int clks);
      btn_n = 1'b0;
      step(clks);
      btn_n = 1'b1;
   endtask

   task automatic wait_req(input logic [3:0] pat, input logic [1:0] src, input string tag);
      int t = 0;
      while (reqs_n === P_IDLE && t < 400) begin step(1); t++; end
      check({tag, "_line"}, 32'(reqs_n), 32'(pat));
      check({tag, "_src"}, 32'(bus.last_src), 32'(src));
   endtask

   task automatic meas_width(input logic [3:0] pat, input string tag);
      int w = 0;
      while (reqs_n === pat && w < 20) begin step(1); w++; end
      check({tag, "_width"}, 32'(w), 32'd4);
   endtask

   initial begin
      int e;
      int seen;
      rst_n = 1'b0;
      pwr_good = 1'b0;
      btn_n = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_type = 2'd0;
      step(3);

      // Reset values
      check("rst_reqs", 32'(reqs_n), 32'(P_IDLE));
      check("rst_ready", 32'(bus.cmd_ready), 32'd0);
      check("rst_src", 32'(bus.last_src), 32'd0);

      // Power-on with pwr_good low through reset
      rst_n = 1'b1;
      step(1);
      check("first_ready", 32'(bus.cmd_ready), 32'(CMD_EN));
      check("por_clk1", 32'(reqs_n), 32'(P_IDLE));
      step(1);
      check("por_clk2", 32'(reqs_n), 32'(P_IDLE));
      step(1);
      check("por_clk3", 32'(reqs_n), 32'(P_POR));
      check("por_src", 32'(bus.last_src), 32'd1);
      check("por_ready", 32'(bus.cmd_ready), 32'd0);
      while (cyc < 100) step(1);
      pwr_good = 1'b1;
      while (bus.por_req_n === 1'b0 && cyc < 400) step(1);
      check_rng("por_release_clk", cyc, 150, 156);
      step(150);

`ifdef RESET_REQ_CMD_EN
      // Hard command, then a soft command held until the lockout ends
      check("cmd_idle_ready", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_type = 2'd1;
      step(1);
      check("cmd_hard_line", 32'(reqs_n), 32'(P_HARD));
      check("cmd_ready_drop", 32'(bus.cmd_ready), 32'd0);
      check("cmd_src", 32'(bus.last_src), 32'd3);
      bus.cmd_type = 2'd0;
      meas_width(P_HARD, "cmd_hard");
      check("cmd_lock_ready", 32'(bus.cmd_ready), 32'd0);
      e = 0;
      while (reqs_n === P_IDLE && e < 200) begin step(1); e++; end
      check("cmd_soft_line", 32'(reqs_n), 32'(P_SOFT));
      check_rng("cmd_lock_clks", e, 54, 63);
      bus.cmd_valid = 1'b0;
      meas_width(P_SOFT, "cmd_soft");
      step(150);
`else
      // Command port disabled: no handshake, no request
      check("nocmd_ready", 32'(bus.cmd_ready), 32'd0);
      bus.cmd_valid = 1'b1;
      bus.cmd_type = 2'd1;
      seen = 0;
      repeat (60) begin
         step(1);
         if (reqs_n !== P_IDLE || bus.cmd_ready !== 1'b0) seen++;
      end
      check("nocmd_quiet", 32'(seen), 32'd0);
      bus.cmd_valid = 1'b0;
`endif

      // Button durations
      press(100);
      wait_req(P_SOFT, 2'd2, "btn10");
      meas_width(P_SOFT, "btn10");
      step(150);
      press(300);
      wait_req(P_HARD, 2'd2, "btn30");
      meas_width(P_HARD, "btn30");
      step(150);
      press(600);
      wait_req(P_FULL, 2'd2, "btn60");
      meas_width(P_FULL, "btn60");
      step(150);
      press(10);
      seen = 0;
      repeat (200) begin
         step(1);
         if (reqs_n !== P_IDLE) seen++;
      end
      check("btn_glitch", 32'(seen), 32'd0);

`ifdef RESET_REQ_CMD_EN
      // Button release and command in the same cycle: button wins
      btn_n = 1'b0;
      step(300);
      while (cyc % 10 != 0) step(1);
      btn_n = 1'b1;
      step(20);
      bus.cmd_valid = 1'b1;
      bus.cmd_type = 2'd0;
      step(1);
      check("race_btn_line", 32'(reqs_n), 32'(P_HARD));
      check("race_btn_src", 32'(bus.last_src), 32'd2);
      meas_width(P_HARD, "race_btn");
      wait_req(P_SOFT, 2'd3, "race_cmd");
      bus.cmd_valid = 1'b0;
      meas_width(P_SOFT, "race_cmd");
      step(150);
`endif

      // Power loss during a soft pulse
      press(100);
      wait_req(P_SOFT, 2'd2, "abort");
      pwr_good = 1'b0;
      step(2);
      check("abort_before", 32'(reqs_n), 32'(P_SOFT));
      step(1);
      check("abort_swap", 32'(reqs_n), 32'(P_POR));
      check("abort_src", 32'(bus.last_src), 32'd1);
      pwr_good = 1'b1;
      step(200);

      // Reset in the middle of lockout
      press(100);
      wait_req(P_SOFT, 2'd2, "midrst");
      meas_width(P_SOFT, "midrst");
      step(10);
      rst_n = 1'b0;
      #1;
      check("midrst_reqs", 32'(reqs_n), 32'(P_IDLE));
      check("midrst_ready", 32'(bus.cmd_ready), 32'd0);
      check("midrst_src", 32'(bus.last_src), 32'd0);
      step(3);
      rst_n = 1'b1;
      step(1);
      check("midrst_ready_after", 32'(bus.cmd_ready), 32'(CMD_EN));
      check("midrst_reqs_after", 32'(reqs_n), 32'(P_IDLE));
      step(5);

      check("onehot_reqs", 32'(onehot_bad), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
